reg_file_8x8: RTL

- General-purpose register file for the 8-bit single-cycle processor; sits directly upstream and downstream of the ALU.
- Two combinational read ports supply OPERAND1/OPERAND2 to the ALU; one clocked write port captures ALURESULT (or an immediate) at the end of each instruction cycle.
- Tracks which registers have been written since reset and flags reads of never-written registers, for debug and verification.

---
 rtl/reg_file_8x8.sv | 52 +++++
 1 files changed

// File: rtl/reg_file_8x8.sv
// 8-entry register file: two combinational read ports, one clocked write port.
// Ports: CLK, RESET_N, IN/INADDRESS/WRITE, OUT1/OUT2 + addresses, WRITTEN, UNINIT_READ.
module reg_file_8x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter bit BYPASS     = 1'b0,
    localparam int NREGS     = 2 ** ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2,
    output logic [NREGS-1:0]      WRITTEN,
    output logic                  UNINIT_READ
);

    logic [DATA_WIDTH-1:0] mem [NREGS];
    logic [NREGS-1:0]      wr_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            wr_q <= '0;
        end else if (WRITE) begin
            mem[INADDRESS]  <= IN;
            wr_q[INADDRESS] <= 1'b1;
        end
    end

    // Forwarding is gated by RESET_N so a held reset always reads 0.
    logic fwd1;
    logic fwd2;

    always_comb begin
        fwd1 = BYPASS && RESET_N && WRITE && (INADDRESS == OUT1ADDRESS);
        fwd2 = BYPASS && RESET_N && WRITE && (INADDRESS == OUT2ADDRESS);
        OUT1 = fwd1 ? IN : mem[OUT1ADDRESS];
        OUT2 = fwd2 ? IN : mem[OUT2ADDRESS];
    end

    // Reflects stored state only; forwarding never clears the flag early.
    assign WRITTEN     = wr_q;
    assign UNINIT_READ = ~wr_q[OUT1ADDRESS] | ~wr_q[OUT2ADDRESS];

endmodule
